// File: rtl/ptw_arbiter_pkg.sv
// Shared types and default parameters for the page-table-walk arbiter.
package ptw_arbiter_pkg;

  localparam int DEF_N_REQ    = 2;
  localparam int DEF_VPN_BITS = 27;
  localparam int DEF_PPN_BITS = 54;
  localparam int DEF_TIMEOUT  = 1024;

  typedef struct packed {
    logic [DEF_PPN_BITS-1:0] ppn;
    logic d;
    logic a;
    logic g;
    logic u;
    logic x;
    logic w;
    logic r;
    logic v;
  } pte_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } state_e;

endpackage

// File: rtl/ptw_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o
);

  logic [ID_W-1:0] idx;
  logic            found;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = ID_W'((int'(ptr_i) + off) % N);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between requesters, with sfence discard and a response watchdog.
module ptw_arbiter
  import ptw_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int VPN_BITS = DEF_VPN_BITS,
  parameter int PPN_BITS = DEF_PPN_BITS,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_req_0_valid,
  output logic                io_req_0_ready,
  input  logic [VPN_BITS-1:0] io_req_0_bits_vpn,
  input  logic                io_req_1_valid,
  output logic                io_req_1_ready,
  input  logic [VPN_BITS-1:0] io_req_1_bits_vpn,
  output logic                io_resp_0_valid,
  output logic                io_resp_0_bits_ae,
  output logic [PPN_BITS-1:0] io_resp_0_bits_pte_ppn,
  output logic                io_resp_0_bits_pte_d,
  output logic                io_resp_0_bits_pte_a,
  output logic                io_resp_0_bits_pte_g,
  output logic                io_resp_0_bits_pte_u,
  output logic                io_resp_0_bits_pte_x,
  output logic                io_resp_0_bits_pte_w,
  output logic                io_resp_0_bits_pte_r,
  output logic                io_resp_0_bits_pte_v,
  output logic                io_resp_1_valid,
  output logic                io_resp_1_bits_ae,
  output logic [PPN_BITS-1:0] io_resp_1_bits_pte_ppn,
  output logic                io_resp_1_bits_pte_d,
  output logic                io_resp_1_bits_pte_a,
  output logic                io_resp_1_bits_pte_g,
  output logic                io_resp_1_bits_pte_u,
  output logic                io_resp_1_bits_pte_x,
  output logic                io_resp_1_bits_pte_w,
  output logic                io_resp_1_bits_pte_r,
  output logic                io_resp_1_bits_pte_v,
  output logic                io_ptw_req_valid,
  input  logic                io_ptw_req_ready,
  output logic [VPN_BITS-1:0] io_ptw_req_bits_vpn,
  input  logic                io_ptw_resp_valid,
  input  logic                io_ptw_resp_bits_ae,
  input  logic [PPN_BITS-1:0] io_ptw_resp_bits_pte_ppn,
  input  logic                io_ptw_resp_bits_pte_d,
  input  logic                io_ptw_resp_bits_pte_a,
  input  logic                io_ptw_resp_bits_pte_g,
  input  logic                io_ptw_resp_bits_pte_u,
  input  logic                io_ptw_resp_bits_pte_x,
  input  logic                io_ptw_resp_bits_pte_w,
  input  logic                io_ptw_resp_bits_pte_r,
  input  logic                io_ptw_resp_bits_pte_v,
  input  logic                io_sfence_valid,
  output logic                io_ptw_kill,
  output logic                io_busy
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       rr_q, rr_d;
  logic [VPN_BITS-1:0]   vpn_q, vpn_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  discard_q, discard_d;
  logic                  ae_q, ae_d;
  pte_t                  pte_q, pte_d;

  logic [N_REQ-1:0]      req_valid, grant, ready_c, resp_valid_c;
  logic [VPN_BITS-1:0]   req_vpn [N_REQ];
  logic [ID_W-1:0]       win_id, next_id;
  logic                  ptw_req_valid_c, kill_c, discard_now;
  pte_t                  walk_pte;

  assign req_valid  = {io_req_1_valid, io_req_0_valid};
  assign req_vpn[0] = io_req_0_bits_vpn;
  assign req_vpn[1] = io_req_1_bits_vpn;

  assign walk_pte = '{ppn: io_ptw_resp_bits_pte_ppn,
                      d: io_ptw_resp_bits_pte_d, a: io_ptw_resp_bits_pte_a,
                      g: io_ptw_resp_bits_pte_g, u: io_ptw_resp_bits_pte_u,
                      x: io_ptw_resp_bits_pte_x, w: io_ptw_resp_bits_pte_w,
                      r: io_ptw_resp_bits_pte_r, v: io_ptw_resp_bits_pte_v};

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .valid_i (req_valid),
    .ptr_i   (rr_q),
    .grant_o (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) win_id = ID_W'(i);
    end
  end

  assign next_id     = (owner_q == LAST_ID) ? '0 : owner_q + ID_W'(1);
  assign discard_now = discard_q | io_sfence_valid;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_d            = rr_q;
    vpn_d           = vpn_q;
    cnt_d           = cnt_q;
    discard_d       = discard_q;
    ae_d            = ae_q;
    pte_d           = pte_q;
    ready_c         = '0;
    resp_valid_c    = '0;
    ptw_req_valid_c = 1'b0;
    kill_c          = 1'b0;

    case (state_q)
      IDLE: begin
        ready_c = grant;
        if (|grant) begin
          vpn_d   = req_vpn[win_id];
          owner_d = win_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ptw_req_valid_c = 1'b1;
        if (io_sfence_valid) discard_d = 1'b1;
        if (io_ptw_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        discard_d = discard_now;
        if (io_ptw_resp_valid) begin
          if (discard_now) begin
            state_d = DRAIN;
          end else begin
            ae_d    = io_ptw_resp_bits_ae;
            pte_d   = walk_pte;
            state_d = RESP;
          end
        end else if (cnt_q == CNT_LAST) begin
          // The walker is killed on timeout even when its result would be discarded anyway.
          kill_c = 1'b1;
          if (discard_now) begin
            state_d = DRAIN;
          end else begin
            ae_d    = 1'b1;
            pte_d   = '0;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid_c[owner_q] = 1'b1;
        rr_d                  = next_id;
        state_d               = IDLE;
      end
      DRAIN: begin
        rr_d      = next_id;
        discard_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      vpn_q     <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      ae_q      <= 1'b0;
      pte_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      vpn_q     <= vpn_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
      ae_q      <= ae_d;
      pte_q     <= pte_d;
    end
  end

  // Handshake and pulse outputs are forced low while reset is held, whatever the old state.
  assign io_req_0_ready      = ready_c[0] & ~reset;
  assign io_req_1_ready      = ready_c[1] & ~reset;
  assign io_resp_0_valid     = resp_valid_c[0] & ~reset;
  assign io_resp_1_valid     = resp_valid_c[1] & ~reset;
  assign io_ptw_req_valid    = ptw_req_valid_c & ~reset;
  assign io_ptw_req_bits_vpn = vpn_q;
  assign io_ptw_kill         = kill_c & ~reset;
  assign io_busy             = (state_q != IDLE) & ~reset;

  assign io_resp_0_bits_ae      = ae_q;
  assign io_resp_0_bits_pte_ppn = pte_q.ppn;
  assign io_resp_0_bits_pte_d   = pte_q.d;
  assign io_resp_0_bits_pte_a   = pte_q.a;
  assign io_resp_0_bits_pte_g   = pte_q.g;
  assign io_resp_0_bits_pte_u   = pte_q.u;
  assign io_resp_0_bits_pte_x   = pte_q.x;
  assign io_resp_0_bits_pte_w   = pte_q.w;
  assign io_resp_0_bits_pte_r   = pte_q.r;
  assign io_resp_0_bits_pte_v   = pte_q.v;
  assign io_resp_1_bits_ae      = ae_q;
  assign io_resp_1_bits_pte_ppn = pte_q.ppn;
  assign io_resp_1_bits_pte_d   = pte_q.d;
  assign io_resp_1_bits_pte_a   = pte_q.a;
  assign io_resp_1_bits_pte_g   = pte_q.g;
  assign io_resp_1_bits_pte_u   = pte_q.u;
  assign io_resp_1_bits_pte_x   = pte_q.x;
  assign io_resp_1_bits_pte_w   = pte_q.w;
  assign io_resp_1_bits_pte_r   = pte_q.r;
  assign io_resp_1_bits_pte_v   = pte_q.v;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Self-checking bench for ptw_arbiter: directed scenarios plus randomized walks against a transaction model.
module tb_ptw_arbiter;
  import ptw_arbiter_pkg::*;

  localparam int VW  = DEF_VPN_BITS;
  localparam int PW  = DEF_PPN_BITS;
  localparam int TMO = DEF_TIMEOUT;

  logic          clock, reset;
  logic          rq0, rq1, sfence;
  logic [VW-1:0] v0, v1;
  logic          p_req_ready, p_resp_valid, p_resp_ae;
  pte_t          p_pte;

  wire           rdy0, rdy1, r0_valid, r1_valid, r0_ae, r1_ae;
  wire [PW-1:0]  r0_ppn, r1_ppn;
  wire [7:0]     r0_flags, r1_flags;
  wire           ptw_req_valid, kill, busy;
  wire [VW-1:0]  ptw_vpn;

  int checks = 0;
  int errors = 0;
  int rr_ptr = 0;

  ptw_arbiter dut (
    .clock(clock), .reset(reset),
    .io_req_0_valid(rq0), .io_req_0_ready(rdy0), .io_req_0_bits_vpn(v0),
    .io_req_1_valid(rq1), .io_req_1_ready(rdy1), .io_req_1_bits_vpn(v1),
    .io_resp_0_valid(r0_valid), .io_resp_0_bits_ae(r0_ae), .io_resp_0_bits_pte_ppn(r0_ppn),
    .io_resp_0_bits_pte_d(r0_flags[7]), .io_resp_0_bits_pte_a(r0_flags[6]),
    .io_resp_0_bits_pte_g(r0_flags[5]), .io_resp_0_bits_pte_u(r0_flags[4]),
    .io_resp_0_bits_pte_x(r0_flags[3]), .io_resp_0_bits_pte_w(r0_flags[2]),
    .io_resp_0_bits_pte_r(r0_flags[1]), .io_resp_0_bits_pte_v(r0_flags[0]),
    .io_resp_1_valid(r1_valid), .io_resp_1_bits_ae(r1_ae), .io_resp_1_bits_pte_ppn(r1_ppn),
    .io_resp_1_bits_pte_d(r1_flags[7]), .io_resp_1_bits_pte_a(r1_flags[6]),
    .io_resp_1_bits_pte_g(r1_flags[5]), .io_resp_1_bits_pte_u(r1_flags[4]),
    .io_resp_1_bits_pte_x(r1_flags[3]), .io_resp_1_bits_pte_w(r1_flags[2]),
    .io_resp_1_bits_pte_r(r1_flags[1]), .io_resp_1_bits_pte_v(r1_flags[0]),
    .io_ptw_req_valid(ptw_req_valid), .io_ptw_req_ready(p_req_ready),
    .io_ptw_req_bits_vpn(ptw_vpn),
    .io_ptw_resp_valid(p_resp_valid), .io_ptw_resp_bits_ae(p_resp_ae),
    .io_ptw_resp_bits_pte_ppn(p_pte.ppn),
    .io_ptw_resp_bits_pte_d(p_pte.d), .io_ptw_resp_bits_pte_a(p_pte.a),
    .io_ptw_resp_bits_pte_g(p_pte.g), .io_ptw_resp_bits_pte_u(p_pte.u),
    .io_ptw_resp_bits_pte_x(p_pte.x), .io_ptw_resp_bits_pte_w(p_pte.w),
    .io_ptw_resp_bits_pte_r(p_pte.r), .io_ptw_resp_bits_pte_v(p_pte.v),
    .io_sfence_valid(sfence), .io_ptw_kill(kill), .io_busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic pte_t rand_pte();
    pte_t p;
    p.ppn = PW'({$urandom(), $urandom()});
    {p.d, p.a, p.g, p.u, p.x, p.w, p.r, p.v} = 8'($urandom());
    return p;
  endfunction

  function automatic logic [7:0] flags_of(input pte_t p);
    return {p.d, p.a, p.g, p.u, p.x, p.w, p.r, p.v};
  endfunction

  // Fairness rule: the requester the pointer names wins if it asks, otherwise the other one.
  function automatic int model_winner(input logic [1:0] valids);
    if (valids[rr_ptr]) return rr_ptr;
    return 1 - rr_ptr;
  endfunction

  // One full transaction; starts and ends just after a rising edge with the DUT idle.
  // sf_cyc indexes the busy cycles (ISSUE then WAIT) in which sfence is raised; -1 for none.
  task automatic run_walk(input logic [1:0] valids, input logic [VW-1:0] a0, a1,
                          input int rdy_dly, rsp_dly, input bit tmo, input int sf_cyc,
                          input pte_t pte, input logic ae);
    int         owner, wait_len, c, kills, kill_at, bad_resp;
    bit         disc;
    logic [VW-1:0] exp_vpn;
    owner    = model_winner(valids);
    exp_vpn  = (owner == 0) ? a0 : a1;
    wait_len = tmo ? TMO : rsp_dly + 1;
    disc     = (sf_cyc >= 0) && (sf_cyc < rdy_dly + 1 + wait_len);

    rq0 = valids[0]; rq1 = valids[1]; v0 = a0; v1 = a1;
    sfence = 1'($urandom_range(0, 1));
    p_resp_valid = 1'($urandom_range(0, 1));
    p_pte = rand_pte();
    @(negedge clock);
    check("ready_onehot", {rdy1, rdy0}, (owner == 0) ? 2'b01 : 2'b10);
    check("busy_idle", busy, 1'b0);
    @(posedge clock); #1;
    rq0 = 1'b0; rq1 = 1'b0; sfence = 1'b0;

    c = 0; kills = 0; kill_at = -1; bad_resp = 0;
    for (int d = 0; d <= rdy_dly; d++) begin
      p_req_ready  = (d == rdy_dly);
      sfence       = (c == sf_cyc);
      p_resp_valid = 1'($urandom_range(0, 1));
      p_pte        = rand_pte();
      @(negedge clock);
      check("issue_valid", ptw_req_valid, 1'b1);
      check("issue_vpn", ptw_vpn, exp_vpn);
      kills += int'(kill);
      @(posedge clock); #1;
      c++;
    end
    p_req_ready = 1'b0;
    for (int w = 0; w < wait_len; w++) begin
      sfence = (c == sf_cyc);
      if (!tmo && w == rsp_dly) begin
        p_resp_valid = 1'b1; p_resp_ae = ae; p_pte = pte;
      end else begin
        p_resp_valid = 1'b0; p_resp_ae = 1'($urandom_range(0, 1)); p_pte = rand_pte();
      end
      @(negedge clock);
      if (kill) begin
        kills++;
        kill_at = w;
      end
      bad_resp += int'(r0_valid | r1_valid);
      @(posedge clock); #1;
      c++;
    end
    sfence = 1'b0; p_resp_valid = 1'b0;
    check("kill_count", kills, tmo ? 1 : 0);
    if (tmo) check("kill_cycle", kill_at, TMO - 1);
    check("no_resp_while_walking", bad_resp, 0);

    // RESP or DRAIN cycle; sfence and walker noise here must be ignored.
    if (!disc) sfence = 1'($urandom_range(0, 1));
    p_resp_valid = 1'($urandom_range(0, 1));
    p_resp_ae    = 1'($urandom_range(0, 1));
    p_pte        = rand_pte();
    @(negedge clock);
    check("busy_resp", busy, 1'b1);
    if (disc) begin
      check("drain_no_resp", {r1_valid, r0_valid}, 2'b00);
    end else begin
      check("resp_onehot", {r1_valid, r0_valid}, (owner == 0) ? 2'b01 : 2'b10);
      check("resp_ae", (owner == 0) ? r0_ae : r1_ae, tmo ? 1'b1 : ae);
      check("resp_ppn", (owner == 0) ? r0_ppn : r1_ppn, tmo ? '0 : pte.ppn);
      check("resp_flags", (owner == 0) ? r0_flags : r1_flags, tmo ? 8'h00 : flags_of(pte));
    end
    @(posedge clock); #1;
    sfence = 1'b0; p_resp_valid = 1'b0;
    @(negedge clock);
    check("busy_after", busy, 1'b0);
    check("resp_pulse_end", {r1_valid, r0_valid}, 2'b00);
    if (!disc) check("ppn_hold", r1_ppn, tmo ? '0 : pte.ppn);
    @(posedge clock); #1;
    rr_ptr = (owner + 1) % 2;
  endtask

  initial begin
    pte_t pte;
    int   rdy, rsp, sf;
    logic [1:0] vals;

    reset = 1'b1; sfence = 1'b0;
    p_req_ready = 1'b0; p_resp_valid = 1'b0; p_resp_ae = 1'b0; p_pte = '0;
    rq0 = 1'b1; rq1 = 1'b1; v0 = VW'(32'h1000); v1 = VW'(32'h2000);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_ready", {rdy1, rdy0}, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_ptw_valid", ptw_req_valid, 1'b0);
    check("reset_kill", kill, 1'b0);
    check("reset_resp", {r1_valid, r0_valid}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0;

    // Both requesters pending at reset exit; shortest possible walk for requester 0.
    pte = '0;
    pte.ppn = PW'(32'h12345);
    pte.v = 1'b1; pte.r = 1'b1; pte.w = 1'b1; pte.a = 1'b1; pte.d = 1'b1;
    run_walk(2'b11, VW'(32'h1000), VW'(32'h2000), 0, 0, 1'b0, -1, pte, 1'b0);
    run_walk(2'b11, VW'(32'h1000), VW'(32'h2000), 1, 2, 1'b0, -1, rand_pte(), 1'b0);

    // Walker never answers; afterwards the arbiter must accept a new request.
    run_walk(2'b01, VW'(32'h0333), VW'(32'h0444), 0, 0, 1'b1, -1, rand_pte(), 1'b0);
    run_walk(2'b11, VW'(32'h0555), VW'(32'h0666), 0, 1, 1'b0, -1, rand_pte(), 1'b1);

    // sfence in WAIT, answer 5 cycles later; following grant shows the pointer moved.
    run_walk(2'b11, VW'(32'h0777), VW'(32'h0888), 0, 5, 1'b0, 1, rand_pte(), 1'b0);
    run_walk(2'b11, VW'(32'h0999), VW'(32'h0AAA), 0, 0, 1'b0, -1, rand_pte(), 1'b0);
    // sfence in ISSUE, and sfence coincident with the walker response.
    run_walk(2'b11, VW'(32'h0BBB), VW'(32'h0CCC), 2, 3, 1'b0, 0, rand_pte(), 1'b0);
    run_walk(2'b11, VW'(32'h0DDD), VW'(32'h0EEE), 0, 3, 1'b0, 4, rand_pte(), 1'b0);
    // Timeout while a discard is pending: kill still pulses, nothing is returned.
    run_walk(2'b10, VW'(32'h0111), VW'(32'h0222), 0, 0, 1'b1, 300, rand_pte(), 1'b0);

    // Reset in the middle of a walk.
    rq0 = 1'b1; v0 = VW'(32'h0ABC); rq1 = 1'b0;
    @(negedge clock);
    check("rst_walk_ready", {rdy1, rdy0}, 2'b01);
    @(posedge clock); #1;
    rq0 = 1'b0; p_req_ready = 1'b1;
    @(posedge clock); #1;
    p_req_ready = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1; rq1 = 1'b1;
    @(negedge clock);
    check("midwalk_rst_busy", busy, 1'b0);
    check("midwalk_rst_ready", {rdy1, rdy0}, 2'b00);
    check("midwalk_rst_kill", kill, 1'b0);
    check("midwalk_rst_resp", {r1_valid, r0_valid}, 2'b00);
    @(posedge clock); #1;
    reset = 1'b0; rq1 = 1'b0; p_resp_valid = 1'b1;
    @(negedge clock);
    check("post_rst_busy", busy, 1'b0);
    @(posedge clock); #1;
    p_resp_valid = 1'b0;
    @(negedge clock);
    check("late_resp_ignored", {r1_valid, r0_valid}, 2'b00);
    check("late_resp_busy", busy, 1'b0);
    @(posedge clock); #1;
    rr_ptr = 0;
    run_walk(2'b11, VW'(32'h0F00), VW'(32'h0F01), 0, 0, 1'b0, -1, rand_pte(), 1'b0);

    // Only requester 1 asks: it must win every walk.
    for (int i = 0; i < 4; i++) begin
      run_walk(2'b10, VW'($urandom()), VW'($urandom()), i % 2, i, 1'b0, -1, rand_pte(),
               1'($urandom_range(0, 1)));
    end

    // Randomized walks.
    for (int i = 0; i < 24; i++) begin
      vals = 2'($urandom_range(1, 3));
      rdy  = $urandom_range(0, 3);
      rsp  = $urandom_range(0, 6);
      sf   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rdy + rsp + 1) : -1;
      run_walk(vals, VW'($urandom()), VW'($urandom()), rdy, rsp, 1'b0, sf, rand_pte(),
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ptw_arbiter.md
PTW_ARBITER -- requirements
Module: ptw_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, 2, requester count; VPN_BITS, 27, virtual page number width; PPN_BITS, 54, PTE ppn width; TIMEOUT, 1024, walker response watchdog in cycles.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 io_req_N_valid  in  1  requester N (N=0..N_REQ-1) has a translation request.
REQ-005 io_req_N_ready  out  1  request N is accepted this cycle.
REQ-006 io_req_N_bits_vpn  in  VPN_BITS  requested virtual page number.
REQ-007 io_resp_N_valid  out  1  one-cycle response pulse to requester N; no backpressure.
REQ-008 io_resp_N_bits_ae  out  1  access error or timeout.
REQ-009 io_resp_N_bits_pte_ppn  out  PPN_BITS  returned PTE ppn.
REQ-010 io_resp_N_bits_pte_{d,a,g,u,x,w,r,v}  out  1 each  returned PTE flags.
REQ-011 io_ptw_req_valid / io_ptw_req_ready  out / in  1  walker request handshake.
REQ-012 io_ptw_req_bits_vpn  out  VPN_BITS  VPN presented to walker.
REQ-013 io_ptw_resp_valid, io_ptw_resp_bits_ae, io_ptw_resp_bits_pte_*  in  1/1/PTE  walker response, same field layout as REQ-009/010.
REQ-014 io_sfence_valid  in  1  translation flush; current walk result is discarded.
REQ-015 io_ptw_kill  out  1  one-cycle pulse aborting the walker on timeout.
REQ-016 io_busy  out  1  high in every state except IDLE.

Function
REQ-017 State machine SHALL have states IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-018 IDLE: winner = first valid requester at or after rr pointer (wrapping); only the winner's io_req_N_ready SHALL be high, combinationally; all ready low in every other state.
REQ-019 On request handshake: capture vpn and owner id, go ISSUE.
REQ-020 ISSUE: io_ptw_req_valid=1 with captured vpn; on io_ptw_req_ready go WAIT, clear watchdog counter.
REQ-021 WAIT: on io_ptw_resp_valid latch ae and all PTE fields, go RESP; otherwise increment counter.
REQ-022 Counter reaching TIMEOUT-1 in WAIT without response SHALL pulse io_ptw_kill, latch ae=1 and PTE all-zero, go RESP.
REQ-023 RESP: io_resp_<owner>_valid=1 for exactly one cycle with latched fields; other resp_valid low; rr pointer = (owner+1) mod N_REQ; go IDLE.
REQ-024 io_sfence_valid in ISSUE sets a discard flag; in WAIT also sets it. With flag set, walker response or timeout SHALL go DRAIN (no resp_valid) instead of RESP; DRAIN lasts one cycle, advances rr pointer, clears flag, goes IDLE.
REQ-025 io_sfence_valid in IDLE or RESP SHALL have no effect; sfence coincident with walker response in WAIT SHALL discard that response.
REQ-026 io_ptw_resp_valid outside WAIT SHALL be ignored.
REQ-027 Minimum latency: handshake cycle T, ptw_req_valid T+1, walker ready T+1 and response T+2 gives resp_valid at T+3.
REQ-028 resp pte/ae outputs SHALL hold latched values outside RESP; only valid is qualified.

Reset
REQ-029 reset SHALL force IDLE, rr pointer=0, counter=0, discard flag=0, latched PTE/ae=0; all valid, ready, kill, busy outputs low during and one cycle after... on the first cycle after reset deassertion only IDLE behaviour applies.
REQ-030 reset asserted mid-walk SHALL abandon the walk with no response and no kill pulse.

Structure
REQ-031 Shared package SHALL hold the PTE struct (ppn + 8 flags), the state enum, and defaults for N_REQ, VPN_BITS, PPN_BITS, TIMEOUT.
REQ-032 Winner selection SHALL be a separate sub-module rr_arbiter (valid vector + pointer in, one-hot grant out, combinational).

Verification
REQ-033 Both requesters valid at reset exit, vpn 0x1000/0x2000 -> req 0 granted, walker sees 0x1000, resp_0 pulse; then req 1 granted, walker sees 0x2000.
REQ-034 Walker returns ppn 0x12345, flags v,r,w,a,d -> requester gets identical fields, ae=0, resp_valid exactly one cycle at T+3.
REQ-035 Walker never responds -> kill pulse at WAIT cycle 1024, resp ae=1, ppn 0, then IDLE accepts next request.
REQ-036 sfence in WAIT, walker responds 5 cycles later -> no resp_valid, busy falls after DRAIN, pointer advanced.
REQ-037 reset asserted in WAIT -> next cycle IDLE, busy=0, late walker response ignored.
REQ-038 Only req 1 valid repeatedly -> granted back-to-back every walk (pointer wrap, no starvation).
